// File: rtl/oled_refresh.sv
// Streams one full frame (8 pages x {3 command bytes, 128 RAM bytes}) to the OLED panel.
// Each byte is an 18-cycle SPI slot; RAM is read one slot ahead to hide its 1-cycle latency.
module oled_refresh #(
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic       clk_1m,
    input  logic       RST_n,
    input  logic       initial_done,
    input  logic       refresh_start,
    output logic [9:0] ram_addr,
    input  logic [7:0] ram_data,
    output logic [3:0] spi_out,
    output logic       refresh_busy,
    output logic       refresh_done
);

    typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cyc_q, cyc_d;
    logic [1:0]  cmd_idx_q, cmd_idx_d;
    logic [2:0]  page_q, page_d;
    logic [6:0]  col_q, col_d;
    logic [7:0]  byte_q, byte_d;
    logic [9:0]  addr_q, addr_d;

    logic        nxt_data, last_byte;
    logic [2:0]  nxt_page;
    logic [6:0]  nxt_col;
    logic [1:0]  nxt_cmd_idx;
    logic [7:0]  nxt_cmd_byte;
    logic [2:0]  bit_sel;
    logic        dc;

    // Identify the byte that follows the one currently being shifted out.
    always_comb begin
        nxt_data    = 1'b0;
        last_byte   = 1'b0;
        nxt_page    = page_q;
        nxt_col     = 7'd0;
        nxt_cmd_idx = 2'd0;
        if (state_q == StCmd) begin
            if (cmd_idx_q == 2'd2) begin
                nxt_data = 1'b1;
            end else begin
                nxt_cmd_idx = cmd_idx_q + 2'd1;
            end
        end else if (state_q == StData) begin
            if (col_q != 7'd127) begin
                nxt_data = 1'b1;
                nxt_col  = col_q + 7'd1;
            end else if (page_q != 3'd7) begin
                nxt_page = page_q + 3'd1;
            end else begin
                last_byte = 1'b1;
            end
        end
        case (nxt_cmd_idx)
            2'd0:    nxt_cmd_byte = {5'b10110, nxt_page};
            2'd1:    nxt_cmd_byte = 8'h00;
            default: nxt_cmd_byte = 8'h10;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        cmd_idx_d = cmd_idx_q;
        page_d    = page_q;
        col_d     = col_q;
        byte_d    = byte_q;
        addr_d    = addr_q;
        unique case (state_q)
            StIdle: begin
                if (refresh_start && initial_done) begin
                    state_d = StCmd;
                    byte_d  = 8'hB0;
                end
            end
            StCmd, StData: begin
                if (!initial_done) begin
                    state_d   = StIdle;
                    cyc_d     = 5'd0;
                    cmd_idx_d = 2'd0;
                    page_d    = 3'd0;
                    col_d     = 7'd0;
                end else begin
                    cyc_d = (cyc_q == 5'd17) ? 5'd0 : cyc_q + 5'd1;
                    if (cyc_q == 5'd15 && nxt_data) begin
                        addr_d = {nxt_page, nxt_col};
                    end
                    if (cyc_q == 5'd17) begin
                        if (last_byte) begin
                            state_d   = StDone;
                            cmd_idx_d = 2'd0;
                            page_d    = 3'd0;
                            col_d     = 7'd0;
                        end else begin
                            state_d   = nxt_data ? StData : StCmd;
                            cmd_idx_d = nxt_cmd_idx;
                            page_d    = nxt_page;
                            col_d     = nxt_col;
                            byte_d    = nxt_data ? ram_data : nxt_cmd_byte;
                        end
                    end
                end
            end
            StDone: begin
                if (CONTINUOUS && initial_done) begin
                    state_d = StCmd;
                    byte_d  = 8'hB0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_1m or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= StIdle;
            cyc_q     <= 5'd0;
            cmd_idx_q <= 2'd0;
            page_q    <= 3'd0;
            col_q     <= 7'd0;
            byte_q    <= 8'h00;
            addr_q    <= 10'd0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            cmd_idx_q <= cmd_idx_d;
            page_q    <= page_d;
            col_q     <= col_d;
            byte_q    <= byte_d;
            addr_q    <= addr_d;
        end
    end

    // Slot cycle 2k carries bit 7-k; odd cycles raise sclk with sdin held.
    always_comb begin
        bit_sel      = 3'd7 - cyc_q[3:1];
        dc           = (state_q == StData);
        refresh_busy = (state_q == StCmd) || (state_q == StData);
        refresh_done = (state_q == StDone);
        ram_addr     = addr_q;
        spi_out      = 4'b1000;
        if (refresh_busy) begin
            if (cyc_q < 5'd16) begin
                spi_out = {1'b0, dc, cyc_q[0], byte_q[bit_sel]};
            end else begin
                spi_out = {1'b1, dc, 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_oled_refresh.sv
// Bench for oled_refresh: SPI byte decoder feeds a scoreboard of expected {dc, byte} values.
`timescale 1ns/1ps
module tb_oled_refresh;

    logic       clk = 1'b0;
    logic       rst_n0, rst_n1, init0, init1, start0, start1;
    logic [9:0] addr0, addr1;
    logic [7:0] rd0, rd1;
    logic [3:0] spi0, spi1;
    logic       busy0, busy1, done0, done1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    always #500 clk = ~clk;

    oled_refresh #(.CONTINUOUS(1'b0)) dut0 (
        .clk_1m(clk), .RST_n(rst_n0), .initial_done(init0), .refresh_start(start0),
        .ram_addr(addr0), .ram_data(rd0), .spi_out(spi0), .refresh_busy(busy0),
        .refresh_done(done0)
    );

    oled_refresh #(.CONTINUOUS(1'b1)) dut1 (
        .clk_1m(clk), .RST_n(rst_n1), .initial_done(init1), .refresh_start(start1),
        .ram_addr(addr1), .ram_data(rd1), .spi_out(spi1), .refresh_busy(busy1),
        .refresh_done(done1)
    );

    // Frame-buffer model: byte at address a is a[7:0], one-cycle read latency.
    always_ff @(posedge clk) begin
        rd0 <= addr0[7:0];
        rd1 <= addr1[7:0];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [8:0] exp_byte(input int i);
        int p, b;
        logic [7:0] pb;
        p  = i / 131;
        b  = i % 131;
        pb = 8'(p);
        if (b == 0) return {1'b0, 8'hB0 + pb};
        if (b == 1) return 9'h000;
        if (b == 2) return 9'h010;
        return {1'b1, pb[0], 7'(b - 3)};
    endfunction

    task automatic push0(input int n);
        for (int i = 0; i < n; i++) q0.push_back(exp_byte(i));
    endtask

    int         bits0 = 0, bits1 = 0;
    logic [7:0] sh0, sh1;
    logic       dcf0, dcf1;

    always @(negedge clk) begin
        if (spi0[3]) begin
            bits0 = 0;
        end else if (spi0[1]) begin
            if (bits0 == 0) dcf0 = spi0[2];
            sh0 = {sh0[6:0], spi0[0]};
            bits0++;
            if (bits0 == 8) begin
                bits0 = 0;
                if (q0.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL dut0_byte_unexpected: got %0h, expected none", {dcf0, sh0});
                end else begin
                    check("dut0_byte", {dcf0, sh0}, q0.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (spi1[3]) begin
            bits1 = 0;
        end else if (spi1[1]) begin
            if (bits1 == 0) dcf1 = spi1[2];
            sh1 = {sh1[6:0], spi1[0]};
            bits1++;
            if (bits1 == 8) begin
                bits1 = 0;
                if (q1.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL dut1_byte_unexpected: got %0h, expected none", {dcf1, sh1});
                end else begin
                    check("dut1_byte", {dcf1, sh1}, q1.pop_front());
                end
            end
        end
    end

    // One frame on dut0; optional extra start, initial_done drop, or reset at a busy-cycle index.
    task automatic run_frame(input int restart_at, input int drop_at, input int rst_at,
                             output int len, output logic dn);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("first_slot_busy", busy0, 1);
        check("first_slot_cs", spi0[3], 0);
        len = 0;
        dn  = 1'b0;
        for (int idx = 0; idx < 20000; idx++) begin
            if (!busy0) break;
            len    = idx + 1;
            start0 = (idx == restart_at);
            if (idx == 2410 && drop_at < 0 && rst_at < 0) check("page1_addr", addr0, 10'h080);
            if (idx == drop_at) init0 = 1'b0;
            if (idx == rst_at) begin
                #2 rst_n0 = 1'b0;
                #1;
                check("async_rst_spi", spi0, 4'b1000);
                check("async_rst_busy", busy0, 0);
                check("async_rst_done", done0, 0);
                check("async_rst_addr", addr0, 0);
                return;
            end
            @(negedge clk);
            if (done0) begin
                dn = 1'b1;
                break;
            end
        end
        start0 = 1'b0;
    endtask

    task automatic seq0();
        int   len, active;
        logic dn;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        active = 0;
        repeat (40) begin
            if (busy0 || spi0 != 4'b1000) active++;
            @(negedge clk);
        end
        check("start_without_init", active, 0);
        init0 = 1'b1;
        repeat (2) @(negedge clk);

        push0(1048);
        run_frame(-1, -1, -1, len, dn);
        check("frame1_len", len, 18864);
        check("frame1_done", dn, 1);
        @(negedge clk);
        check("done_one_cycle", done0, 0);
        check("idle_after_done", busy0, 0);
        check("idle_spi", spi0, 4'b1000);
        check("idle_addr_held", addr0, 10'h3FF);

        push0(1048);
        run_frame(5000, -1, -1, len, dn);
        check("restart_ignored_len", len, 18864);
        check("restart_ignored_done", dn, 1);
        @(negedge clk);

        push0(277);
        run_frame(-1, 5000, -1, len, dn);
        check("abort_len", len, 5001);
        check("abort_spi", spi0, 4'b1000);
        active = 0;
        repeat (30) begin
            if (done0 || busy0) active++;
            @(negedge clk);
        end
        check("abort_no_done", active, 0);
        init0 = 1'b1;
        @(negedge clk);

        push0(10);
        run_frame(-1, -1, 187, len, dn);
        @(negedge clk);
        check("reset_held_idle", busy0, 0);
        rst_n0 = 1'b1;
        @(negedge clk);
        check("bytes_before_reset", q0.size(), 0);

        push0(1048);
        run_frame(-1, -1, -1, len, dn);
        check("post_reset_len", len, 18864);
        check("post_reset_done", dn, 1);
        @(negedge clk);
    endtask

    task automatic seq1();
        int   len2;
        logic seen;
        init1 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2096; i++) q1.push_back(exp_byte(i % 1048));
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (done1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("cont_first_done", seen, 1);
        @(negedge clk);
        check("cont_restart_busy", busy1, 1);
        check("cont_restart_cs", spi1[3], 0);
        len2 = 1;
        seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done1) begin
                seen = 1'b1;
                break;
            end
            len2++;
        end
        check("cont_second_done", seen, 1);
        check("cont_second_len", len2, 18864);
        init1 = 1'b0;
        @(negedge clk);
        check("cont_stop_busy", busy1, 0);
    endtask

    initial begin
        #90_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        init0  = 1'b0; init1  = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_spi", spi0, 4'b1000);
        check("reset_busy", busy0, 0);
        check("reset_done", done0, 0);
        check("reset_addr", addr0, 0);
        check("reset_spi1", spi1, 4'b1000);
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        @(negedge clk);
        fork
            seq0();
            seq1();
        join
        repeat (5) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
